hash_job_controller: RTL and testbench

Parametrised successor to the single-core main controller plus 80-byte register bank. It assembles a block header from bytes delivered by the I2C transceiver and splits the nonce space across NUM_CORES hashing cores. It starts all cores together, arbitrates their completion, and returns the winning nonce to the transceiver through a ready/ack handshake. It sits between i2c_transceiver and the hashing-core array in the top level.

---
 rtl/hash_job_controller_if.sv | 30 +++
 rtl/hash_job_controller.sv | 122 ++++++++++++
 tb/tb_hash_job_controller.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/hash_job_controller_if.sv
// Handshake/bus bundle between the transceiver, the job controller and the hashing-core array.
// master = controller view, slave = environment (transceiver + cores) view.
interface hash_job_controller_if #(
    parameter int unsigned HDR_BYTES = 80,
    parameter int unsigned NUM_CORES = 4,
    parameter int unsigned NONCE_W   = 32
) ();
    logic                         rx_notify;
    logic [7:0]                   rx_command;
    logic [7:0]                   rx_out;
    logic [HDR_BYTES*8-1:0]       hash_data;
    logic [NUM_CORES-1:0]         start_hash;
    logic [NUM_CORES*NONCE_W-1:0] core_nonce_base;
    logic [NUM_CORES-1:0]         hash_done;
    logic [NUM_CORES*NONCE_W-1:0] core_nonce;
    logic                         nonce_ready;
    logic [NONCE_W-1:0]           nonce;
    logic                         nonce_ack;
    logic                         busy;

    modport master (
        input  rx_notify, rx_command, rx_out, hash_done, core_nonce, nonce_ack,
        output hash_data, start_hash, core_nonce_base, nonce_ready, nonce, busy
    );

    modport slave (
        output rx_notify, rx_command, rx_out, hash_done, core_nonce, nonce_ack,
        input  hash_data, start_hash, core_nonce_base, nonce_ready, nonce, busy
    );
endinterface

// File: rtl/hash_job_controller.sv
// Header bank plus multi-core job controller: loads the block header byte-wise, starts all cores
// on disjoint nonce ranges, and reports the lowest-index winning nonce via a ready/ack handshake.
module hash_job_controller #(
    parameter int unsigned HDR_BYTES = 80,
    parameter int unsigned NUM_CORES = 4,
    parameter int unsigned NONCE_W   = 32
) (
    input  logic                   clk,
    input  logic                   n_rst,
    hash_job_controller_if.master  bus
);
    localparam int unsigned    PTR_W    = $clog2(HDR_BYTES + 1);
    localparam int unsigned    CORE_W   = $clog2(NUM_CORES);
    localparam logic [PTR_W-1:0] PTR_FULL = PTR_W'(HDR_BYTES);

    localparam logic [7:0] CMD_LOAD  = 8'h01;
    localparam logic [7:0] CMD_RSTP  = 8'h02;
    localparam logic [7:0] CMD_START = 8'h03;
    localparam logic [7:0] CMD_ABORT = 8'h04;

    typedef enum logic [1:0] {IDLE, DISPATCH, RUN, REPORT} state_t;

    state_t                       state_q;
    logic [PTR_W-1:0]             ptr_q;
    logic [HDR_BYTES*8-1:0]       hash_data_q;
    logic [NUM_CORES-1:0]         start_hash_q;
    logic                         nonce_ready_q;
    logic                         busy_q;
    logic [NONCE_W-1:0]           nonce_q;
    logic [NONCE_W-1:0]           nonce_d;
    logic [NUM_CORES*NONCE_W-1:0] core_base;
    logic                         cmd_load, cmd_rstp, cmd_start, cmd_abort;
    logic                         hdr_full;

    assign cmd_load  = bus.rx_notify && (bus.rx_command == CMD_LOAD);
    assign cmd_rstp  = bus.rx_notify && (bus.rx_command == CMD_RSTP);
    assign cmd_start = bus.rx_notify && (bus.rx_command == CMD_START);
    assign cmd_abort = bus.rx_notify && (bus.rx_command == CMD_ABORT);
    assign hdr_full  = (ptr_q == PTR_FULL);

    // Scan from the top down so the lowest set index is the final assignment.
    always_comb begin
        nonce_d = '0;
        for (int unsigned k = NUM_CORES; k > 0; k--) begin
            if (bus.hash_done[k-1]) begin
                nonce_d = bus.core_nonce[(k-1)*NONCE_W +: NONCE_W];
            end
        end
    end

    // Each core gets an equal slice of the nonce space, keyed by the top CORE_W bits.
    always_comb begin
        core_base = '0;
        for (int unsigned k = 0; k < NUM_CORES; k++) begin
            core_base[k*NONCE_W +: NONCE_W] = NONCE_W'(k) << (NONCE_W - CORE_W);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            hash_data_q <= '0;
        end else if (state_q == IDLE && cmd_load && !hdr_full) begin
            hash_data_q[{ptr_q, 3'b000} +: 8] <= bus.rx_out;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            start_hash_q  <= '0;
            nonce_ready_q <= 1'b0;
            busy_q        <= 1'b0;
            nonce_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_load && !hdr_full) begin
                        ptr_q <= ptr_q + 1'b1;
                    end else if (cmd_rstp) begin
                        ptr_q <= '0;
                    end else if (cmd_start && hdr_full) begin
                        state_q      <= DISPATCH;
                        start_hash_q <= '1;
                        busy_q       <= 1'b1;
                    end
                end
                DISPATCH: begin
                    state_q      <= RUN;
                    start_hash_q <= '0;
                end
                RUN: begin
                    if (cmd_abort) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (|bus.hash_done) begin
                        state_q       <= REPORT;
                        nonce_q       <= nonce_d;
                        nonce_ready_q <= 1'b1;
                    end
                end
                REPORT: begin
                    if (cmd_abort || bus.nonce_ack) begin
                        state_q       <= IDLE;
                        nonce_ready_q <= 1'b0;
                        busy_q        <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.hash_data       = hash_data_q;
    assign bus.start_hash      = start_hash_q;
    assign bus.core_nonce_base = core_base;
    assign bus.nonce_ready     = nonce_ready_q;
    assign bus.nonce           = nonce_q;
    assign bus.busy            = busy_q;
endmodule

// File: tb/tb_hash_job_controller.sv
// Self-checking bench for hash_job_controller: directed scenarios followed by random traffic,
// all compared against a behavioural header/job model.
module tb_hash_job_controller;
    localparam int unsigned HDR = 80;
    localparam int unsigned NC  = 4;
    localparam int unsigned NW  = 32;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    hash_job_controller_if #(.HDR_BYTES(HDR), .NUM_CORES(NC), .NONCE_W(NW)) bus ();

    hash_job_controller #(.HDR_BYTES(HDR), .NUM_CORES(NC), .NONCE_W(NW)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: header as a byte array, job progress as plain flags.
    logic [7:0]    m_hdr [HDR];
    int            m_ptr;
    bit            m_busy, m_disp, m_ready;
    logic [NW-1:0] m_nonce;
    logic [NW-1:0] cn [NC];

    task automatic check_val(input string tag, input logic [HDR*8-1:0] got, input logic [HDR*8-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [HDR*8-1:0] hdr_vec();
        logic [HDR*8-1:0] v;
        for (int i = 0; i < HDR; i++) v[i*8 +: 8] = m_hdr[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < HDR; i++) m_hdr[i] = 8'h00;
        m_ptr = 0; m_busy = 0; m_disp = 0; m_ready = 0; m_nonce = '0;
    endtask

    task automatic check_outputs();
        check_val("hash_data",   bus.hash_data, hdr_vec());
        check_val("start_hash",  bus.start_hash, m_disp ? {NC{1'b1}} : '0);
        check_val("busy",        bus.busy, m_busy);
        check_val("nonce_ready", bus.nonce_ready, m_ready);
        check_val("nonce",       bus.nonce, m_nonce);
    endtask

    // Drive one cycle of inputs (at a negedge), advance the model, check at the next negedge.
    task automatic step(input bit nt, input logic [7:0] cmd, input logic [7:0] dat,
                        input logic [NC-1:0] done, input bit ack);
        bit abort_c;
        bus.rx_notify  = nt;
        bus.rx_command = cmd;
        bus.rx_out     = dat;
        bus.hash_done  = done;
        bus.nonce_ack  = ack;
        for (int k = 0; k < NC; k++) bus.core_nonce[k*NW +: NW] = cn[k];
        abort_c = nt && cmd == 8'h04;
        if (!m_busy) begin
            if (nt && cmd == 8'h01) begin
                if (m_ptr < HDR) begin
                    m_hdr[m_ptr] = dat;
                    m_ptr++;
                end
            end else if (nt && cmd == 8'h02) begin
                m_ptr = 0;
            end else if (nt && cmd == 8'h03 && m_ptr == HDR) begin
                m_busy = 1; m_disp = 1;
            end
        end else if (m_disp) begin
            m_disp = 0;
        end else if (!m_ready) begin
            if (abort_c) begin
                m_busy = 0;
            end else if (done != 0) begin
                for (int k = 0; k < NC; k++) begin
                    if (done[k]) begin
                        m_nonce = cn[k];
                        break;
                    end
                end
                m_ready = 1;
            end
        end else if (abort_c || ack) begin
            m_ready = 0; m_busy = 0;
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle();
        step(1'b0, 8'h00, 8'h00, '0, 1'b0);
    endtask

    initial begin
        logic [NW-1:0] exp_base;
        bus.rx_notify = 0; bus.rx_command = 0; bus.rx_out = 0;
        bus.hash_done = '0; bus.core_nonce = '0; bus.nonce_ack = 0;
        for (int k = 0; k < NC; k++) cn[k] = '0;
        model_reset();

        // Reset values
        @(negedge clk);
        @(negedge clk);
        check_outputs();
        n_rst = 1'b1;

        // Header load, overflow write dropped
        for (int i = 0; i < HDR; i++) step(1'b1, 8'h01, 8'(i), '0, 1'b0);
        check_val("byte0",  bus.hash_data[7:0], 8'h00);
        check_val("byte79", bus.hash_data[639:632], 8'h4F);
        step(1'b1, 8'h01, 8'hFF, '0, 1'b0);

        for (int k = 0; k < NC; k++) begin
            exp_base = NW'((longint'(k) << NW) / NC);
            check_val("core_base", bus.core_nonce_base[k*NW +: NW], exp_base);
        end
        check_val("base_core2", bus.core_nonce_base[2*NW +: NW], 32'h8000_0000);
        check_val("base_core3", bus.core_nonce_base[3*NW +: NW], 32'hC000_0000);

        // START, one-cycle dispatch
        step(1'b1, 8'h03, 8'h00, '0, 1'b0);
        check_val("start_all", bus.start_hash, 4'b1111);
        idle();

        // Two cores finish together: lower index wins
        cn[1] = 32'h4000_0123;
        cn[2] = 32'h8000_0456;
        step(1'b0, 8'h00, 8'h00, 4'b0110, 1'b0);
        check_val("win_nonce", bus.nonce, 32'h4000_0123);
        idle();
        step(1'b0, 8'h00, 8'h00, '0, 1'b1);

        // START with an incomplete header is ignored
        step(1'b1, 8'h02, 8'h00, '0, 1'b0);
        for (int i = 0; i < HDR - 1; i++) step(1'b1, 8'h01, 8'($urandom), '0, 1'b0);
        step(1'b1, 8'h03, 8'h00, '0, 1'b0);
        check_val("short_hdr_busy", bus.busy, 1'b0);
        step(1'b1, 8'h01, 8'h5A, '0, 1'b0);
        step(1'b1, 8'h03, 8'h00, '0, 1'b0);
        idle();
        // Header frozen while running
        step(1'b1, 8'h01, 8'hAA, '0, 1'b0);
        step(1'b1, 8'h02, 8'h00, '0, 1'b0);

        // ABORT beats a simultaneous hash_done
        cn[0] = 32'h1234_5678;
        step(1'b1, 8'h04, 8'h00, 4'b0001, 1'b0);
        check_val("abort_busy", bus.busy, 1'b0);
        step(1'b1, 8'h03, 8'h00, '0, 1'b0);
        check_val("restart_all", bus.start_hash, 4'b1111);
        // hash_done during DISPATCH is ignored
        step(1'b0, 8'h00, 8'h00, 4'b0100, 1'b0);
        cn[3] = 32'hDEAD_BEEF;
        step(1'b0, 8'h00, 8'h00, 4'b1000, 1'b0);

        // Asynchronous reset in REPORT
        #3 n_rst = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        n_rst = 1'b1;

        // Random traffic
        for (int c = 0; c < 4000; c++) begin
            int unsigned r;
            logic [7:0] cmd;
            logic [NC-1:0] done;
            r = $urandom_range(0, 999);
            if (r < 450)      cmd = 8'h01;
            else if (r < 455) cmd = 8'h02;
            else if (r < 600) cmd = 8'h03;
            else if (r < 650) cmd = 8'h04;
            else              cmd = 8'($urandom_range(0, 255));
            done = ($urandom_range(0, 4) == 0) ? NC'($urandom) : '0;
            for (int k = 0; k < NC; k++) cn[k] = $urandom;
            step($urandom_range(0, 3) != 0, cmd, 8'($urandom), done, $urandom_range(0, 3) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
